// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SHL/SHR/SAR/ROL/ROR/RCL/RCR/PASS over log2(WIDTH) levels,
// LVL_PER_REG levels per stage, valid/ready on both sides with collapsing bubbles.
module shift_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LVL_PER_REG = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [$clog2(WIDTH)-1:0]   in_count,
  input  logic                       in_carry,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int unsigned L  = $clog2(WIDTH);
  localparam int unsigned R  = (L + LVL_PER_REG - 1) / LVL_PER_REG;
  localparam int unsigned CR = (R > 1) ? R - 1 : 1;

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_SAR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_RCL = 3'd5;
  localparam logic [2:0] OP_RCR = 3'd6;

  // One shift level of 2^k; result packed as {carry, data}.
  function automatic logic [WIDTH:0] lvl(input logic [WIDTH-1:0] d, input logic c,
                                         input logic [2:0] op, input int unsigned k);
    int unsigned    s;
    logic [WIDTH:0] res;
    logic           cl;
    logic           cr;
    s   = 32'd1 << k;
    cl  = |((d >> (WIDTH - s)) & WIDTH'(1));
    cr  = |((d >> (s - 1)) & WIDTH'(1));
    res = {c, d};
    case (op)
      OP_SHL: res = {cl, d << s};
      OP_SHR: res = {cr, d >> s};
      OP_SAR: res = {cr, WIDTH'($signed(d) >>> s)};
      OP_ROL: res = {cl, (d << s) | (d >> (WIDTH - s))};
      OP_ROR: res = {cr, (d >> s) | (d << (WIDTH - s))};
      OP_RCL: res = ({c, d} << s) | ({c, d} >> (WIDTH + 1 - s));
      OP_RCR: begin
        res = ({d, c} >> s) | ({d, c} << (WIDTH + 1 - s));
        res = {res[0], res[WIDTH:1]};
      end
      default: res = {c, d};
    endcase
    return res;
  endfunction

  logic [R-1:0]       vq;
  logic [R-1:0]       load_c;
  logic [WIDTH-1:0]   dq   [R];
  logic               cq   [R];
  logic [TAG_W-1:0]   tq   [R];
  logic [2:0]         opq  [CR];
  logic [L-1:0]       cntq [CR];

  // A stage loads when empty or when its successor drains it this cycle.
  always_comb begin
    load_c        = '0;
    load_c[R-1]   = ~vq[R-1] | out_ready;
    for (int i = int'(R) - 2; i >= 0; i--) begin
      load_c[i] = ~vq[i] | load_c[i+1];
    end
  end

  assign in_ready = load_c[0];

  for (genvar i = 0; i < R; i++) begin : g_stage
    localparam int unsigned LO = i * LVL_PER_REG;
    localparam int unsigned HI = ((i + 1) * LVL_PER_REG > L) ? L : (i + 1) * LVL_PER_REG;

    logic               src_v;
    logic [WIDTH-1:0]   src_d;
    logic               src_c;
    logic [2:0]         src_op;
    logic [L-1:0]       src_cnt;
    logic [TAG_W-1:0]   src_t;
    logic [WIDTH:0]     res;
    logic               v_q;
    logic [WIDTH-1:0]   d_q;
    logic               c_q;
    logic [TAG_W-1:0]   t_q;

    if (i == 0) begin : g_src_in
      assign src_v   = in_valid;
      assign src_d   = in_data;
      assign src_c   = in_carry;
      assign src_op  = in_op;
      assign src_cnt = in_count;
      assign src_t   = in_tag;
    end else begin : g_src_prev
      assign src_v   = vq[i-1];
      assign src_d   = dq[i-1];
      assign src_c   = cq[i-1];
      assign src_op  = opq[i-1];
      assign src_cnt = cntq[i-1];
      assign src_t   = tq[i-1];
    end

    always_comb begin
      res = {src_c, src_d};
      for (int unsigned k = LO; k < HI; k++) begin
        if (((src_cnt >> k) & L'(1)) != '0) begin
          res = lvl(res[WIDTH-1:0], res[WIDTH], src_op, k);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        c_q <= 1'b0;
        t_q <= '0;
      end else if (load_c[i]) begin
        v_q <= src_v;
        d_q <= res[WIDTH-1:0];
        c_q <= res[WIDTH];
        t_q <= src_t;
      end
    end

    assign vq[i] = v_q;
    assign dq[i] = d_q;
    assign cq[i] = c_q;
    assign tq[i] = t_q;

    if (i < R - 1) begin : g_ctl
      logic [2:0]   op_q;
      logic [L-1:0] cnt_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          op_q  <= '0;
          cnt_q <= '0;
        end else if (load_c[i]) begin
          op_q  <= src_op;
          cnt_q <= src_cnt;
        end
      end
      assign opq[i]  = op_q;
      assign cntq[i] = cnt_q;
    end

    // Zero flag is taken from the final level result and registered alongside it.
    if (i == R - 1) begin : g_zero
      logic z_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          z_q <= 1'b0;
        end else if (load_c[i]) begin
          z_q <= (res[WIDTH-1:0] == '0);
        end
      end
      assign out_zero = z_q;
    end
  end

  assign out_valid = vq[R-1];
  assign out_data  = dq[R-1];
  assign out_carry = cq[R-1];
  assign out_tag   = tq[R-1];

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the cpu32e execute stage; successor to the single-stage fixed-width shift slices.
- Performs a full log2(WIDTH)-level shift/rotate in one op: SHL, SHR, SAR, ROL, ROR, RCL, RCR. Produces a result, carry-out and zero flag.
- Uses valid/ready handshakes on input and output, so it can stall under back-pressure from writeback.

Parameters:
- WIDTH, 32, data width; power of two, 8..64.
- LVL_PER_REG, 2, shift levels evaluated combinationally between pipeline registers; 1..log2(WIDTH).
- TAG_W, 4, width of the opaque tag carried alongside each op.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input op present
- in_ready  out  1  block accepts op this cycle
- in_op  in  3  0=SHL 1=SHR 2=SAR 3=ROL 4=ROR 5=RCL 6=RCR 7=PASS
- in_count  in  log2(WIDTH)  shift amount
- in_carry  in  1  carry flag input (RCL/RCR source; passthrough value)
- in_data  in  WIDTH  operand
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_carry  out  1  carry-out
- out_zero  out  1  out_data == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous and active-low.
- Levels: L = log2(WIDTH); level k shifts by 2^k when in_count[k]=1, else passes data and carry through.
- Per-level semantics match the existing slice rule:
  - Left ops: carry = bit WIDTH-2^k of the level input.
  - Right ops: carry = bit 2^k-1 of the level input.
  - SAR fills with the sign bit.
  - ROL/ROR rotate within WIDTH.
  - RCL/RCR rotate through carry over WIDTH+1 bits. The incoming carry enters at bit 2^k-1 (RCL) or bit WIDTH-2^k (RCR).
- count==0: data and carry pass unchanged.
- PASS (op 7): data and carry pass unchanged regardless of count; no X propagation for any op.
- Pipeline:
  - Registers R = ceil(L/LVL_PER_REG). Register i holds the output of levels [i*LVL_PER_REG, min((i+1)*LVL_PER_REG, L)).
  - Latency is R cycles from accept to out_valid when unstalled (WIDTH=32, LVL_PER_REG=2: R=3).
  - The output register is the last pipeline register; out_* are driven directly from it.
- Each stage register has its own valid bit. op, count bits for remaining levels, carry and tag travel with the data.
- Advance rules:
  - Stage i loads when it is empty or stage i+1 loads (last stage: when out_ready).
  - in_ready = stage 0 empty or stage 0 advances.
  - Bubbles collapse. Throughput is 1 op/cycle while out_ready=1.
  - Capacity is R ops.
- Handshakes:
  - Accept on in_valid & in_ready. Transfer out on out_valid & out_ready.
  - out_* are held stable while out_valid & !out_ready.
  - in_ready is combinational from stage valids and out_ready only; it never depends on in_valid.
- out_zero is computed from the final level result and registered with it.
- Reset (including mid-operation): all stage valids clear immediately and asynchronously; in-flight ops are discarded.
  - Output reset values: out_valid=0, out_data=0, out_carry=0, out_zero=0, out_tag=0.
  - in_ready=1 once reset_n is deasserted.
- Widths: in_count has exactly L bits; no modulo is needed. RCL/RCR counts are therefore limited to WIDTH-1.

Test Plan:
- SHL 0x80000001, count 1, carry_in 0, out_ready=1 -> after 3 cycles: out_data=0x00000002, out_carry=1, out_zero=0.
- SAR 0x80000000, count 4 -> 0xF8000000, carry 0; SHR 0x00000010, count 5 -> 0x00000000, carry 1, out_zero=1.
- ROR 0x12345678, count 8 -> 0x78123456, carry 0. RCL 0x80000000, carry_in 1, count 1 -> 0x00000001, carry 1. RCR 0x00000001, carry_in 0, count 1 -> 0x00000000, carry 1.
- PASS 0xDEADBEEF, count 31, carry_in 1 -> 0xDEADBEEF, carry 1. Any op with count 0 returns the input unchanged.
- Back-pressure: issue 5 back-to-back ops (tags 1..5) with out_ready=0 -> in_ready drops after 3 accepts. Raise out_ready -> tags emerge in order 1..5, one per cycle, out_* stable while stalled.
- Pull reset_n low for 1 cycle with 2 ops in flight -> out_valid=0 asynchronously; after release no stale result appears and the next op completes in 3 cycles.
